// File: rtl/cache_ctrl.sv
// Cache controller: serves CPU word requests against the set array, with write-back,
// word-serial refill, a retry compare, whole-cache flush and saturating hit/miss counters.
module cache_ctrl #(
   parameter int TAG_W  = 5,
   parameter int IDX_W  = 3,
   parameter int WORD_W = 2,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cpu_req,
   input  logic                            cpu_wr,
   input  logic [TAG_W+IDX_W+WORD_W-1:0]   cpu_addr,
   input  logic [DATA_W-1:0]               cpu_wdata,
   output logic [DATA_W-1:0]               cpu_rdata,
   output logic                            cpu_ack,
   output logic                            busy,
   input  logic                            flush,
   output logic [IDX_W-1:0]                set_idx,
   output logic                            set_en,
   output logic                            set_cmp,
   output logic                            set_write,
   output logic                            set_rst,
   output logic                            set_valid_in,
   output logic [WORD_W-1:0]               set_word,
   output logic [TAG_W-1:0]                set_tag,
   output logic [DATA_W-1:0]               set_data_in,
   input  logic                            set_hit,
   input  logic                            set_dirty,
   input  logic                            set_valid,
   input  logic                            set_ack,
   input  logic [TAG_W-1:0]                set_tag_out,
   input  logic [DATA_W-1:0]               set_data_out,
   output logic                            mem_req,
   output logic                            mem_wr,
   output logic [TAG_W+IDX_W+WORD_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]               mem_wdata,
   input  logic [DATA_W-1:0]               mem_rdata,
   input  logic                            mem_ack,
   output logic [CNT_W-1:0]                hit_cnt,
   output logic [CNT_W-1:0]                miss_cnt
);

   localparam int AW = TAG_W + IDX_W + WORD_W;
   localparam logic [WORD_W-1:0] LAST_W   = '1;
   localparam logic [WORD_W-1:0] W_ONE    = 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = '1;
   localparam logic [IDX_W-1:0]  IDX_ONE  = 1;
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

   typedef enum logic [2:0] {
      IDLE, COMPARE, WB_RD, WB_MEM, RF_MEM, RF_WR, FLUSH, DONE
   } state_e;

   state_e              state_q;
   logic [TAG_W-1:0]    tag_q, victim_q;
   logic [IDX_W-1:0]    idx_q;
   logic [WORD_W-1:0]   word_q, w_q;
   logic                wr_q, retry_q;
   logic [DATA_W-1:0]   wdata_q, buf_q, rdata_q;
   logic                cpu_ack_q;
   logic [CNT_W-1:0]    hit_q, miss_q;
   logic                set_en_q, set_cmp_q, set_write_q, set_rst_q, set_valid_in_q;
   logic [IDX_W-1:0]    set_idx_q;
   logic [WORD_W-1:0]   set_word_q;
   logic [TAG_W-1:0]    set_tag_q;
   logic [DATA_W-1:0]   set_data_q;
   logic                mem_req_q, mem_wr_q;
   logic [AW-1:0]       mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;

   logic                cmp_d, write_d, rst_d, valid_in_d;
   logic [IDX_W-1:0]    idx_d;
   logic [WORD_W-1:0]   word_d;
   logic [TAG_W-1:0]    tag_d;
   logic [DATA_W-1:0]   data_d;

   // Set command presented when a set-access state (re)raises set_en
   always_comb begin
      cmp_d      = 1'b0;
      write_d    = 1'b0;
      rst_d      = 1'b0;
      valid_in_d = 1'b0;
      idx_d      = idx_q;
      word_d     = w_q;
      tag_d      = tag_q;
      data_d     = buf_q;
      case (state_q)
         COMPARE: begin
            cmp_d   = 1'b1;
            write_d = wr_q;
            word_d  = word_q;
            data_d  = wdata_q;
         end
         RF_WR: begin
            write_d    = 1'b1;
            valid_in_d = 1'b1;
         end
         FLUSH: begin
            rst_d = 1'b1;
            idx_d = set_idx_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         tag_q          <= '0;
         victim_q       <= '0;
         idx_q          <= '0;
         word_q         <= '0;
         w_q            <= '0;
         wr_q           <= 1'b0;
         retry_q        <= 1'b0;
         wdata_q        <= '0;
         buf_q          <= '0;
         rdata_q        <= '0;
         cpu_ack_q      <= 1'b0;
         hit_q          <= '0;
         miss_q         <= '0;
         set_en_q       <= 1'b0;
         set_cmp_q      <= 1'b0;
         set_write_q    <= 1'b0;
         set_rst_q      <= 1'b0;
         set_valid_in_q <= 1'b0;
         set_idx_q      <= '0;
         set_word_q     <= '0;
         set_tag_q      <= '0;
         set_data_q     <= '0;
         mem_req_q      <= 1'b0;
         mem_wr_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
      end else begin
         cpu_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (flush) begin
                  state_q        <= FLUSH;
                  set_en_q       <= 1'b1;
                  set_rst_q      <= 1'b1;
                  set_cmp_q      <= 1'b0;
                  set_write_q    <= 1'b0;
                  set_valid_in_q <= 1'b0;
                  set_idx_q      <= '0;
               end else if (cpu_req) begin
                  tag_q          <= cpu_addr[AW-1 -: TAG_W];
                  idx_q          <= cpu_addr[WORD_W +: IDX_W];
                  word_q         <= cpu_addr[WORD_W-1:0];
                  wr_q           <= cpu_wr;
                  wdata_q        <= cpu_wdata;
                  retry_q        <= 1'b0;
                  state_q        <= COMPARE;
                  set_en_q       <= 1'b1;
                  set_cmp_q      <= 1'b1;
                  set_write_q    <= cpu_wr;
                  set_rst_q      <= 1'b0;
                  set_valid_in_q <= 1'b0;
                  set_idx_q      <= cpu_addr[WORD_W +: IDX_W];
                  set_word_q     <= cpu_addr[WORD_W-1:0];
                  set_tag_q      <= cpu_addr[AW-1 -: TAG_W];
                  set_data_q     <= cpu_wdata;
               end
            end
            COMPARE, WB_RD, RF_WR, FLUSH: begin
               if (!set_en_q) begin
                  set_en_q       <= 1'b1;
                  set_cmp_q      <= cmp_d;
                  set_write_q    <= write_d;
                  set_rst_q      <= rst_d;
                  set_valid_in_q <= valid_in_d;
                  set_idx_q      <= idx_d;
                  set_word_q     <= word_d;
                  set_tag_q      <= tag_d;
                  set_data_q     <= data_d;
               end else if (set_ack) begin
                  set_en_q <= 1'b0;
                  case (state_q)
                     COMPARE: begin
                        // Only the first compare of a request is counted; the retry must hit
                        if (set_hit && set_valid) begin
                           if (!wr_q) rdata_q <= set_data_out;
                           if (!retry_q && hit_q != CNT_MAX) hit_q <= hit_q + CNT_ONE;
                           cpu_ack_q <= 1'b1;
                           state_q   <= DONE;
                        end else begin
                           if (!retry_q && miss_q != CNT_MAX) miss_q <= miss_q + CNT_ONE;
                           w_q <= '0;
                           if (set_valid && set_dirty) begin
                              victim_q <= set_tag_out;
                              state_q  <= WB_RD;
                           end else begin
                              state_q <= RF_MEM;
                           end
                        end
                     end
                     WB_RD: begin
                        buf_q   <= set_data_out;
                        state_q <= WB_MEM;
                     end
                     RF_WR: begin
                        if (w_q == LAST_W) begin
                           w_q     <= '0;
                           retry_q <= 1'b1;
                           state_q <= COMPARE;
                        end else begin
                           w_q     <= w_q + W_ONE;
                           state_q <= RF_MEM;
                        end
                     end
                     default: begin
                        if (set_idx_q == LAST_IDX) begin
                           set_rst_q <= 1'b0;
                           state_q   <= IDLE;
                        end else begin
                           set_idx_q <= set_idx_q + IDX_ONE;
                        end
                     end
                  endcase
               end
            end
            WB_MEM, RF_MEM: begin
               if (!mem_req_q) begin
                  mem_req_q   <= 1'b1;
                  mem_wr_q    <= (state_q == WB_MEM);
                  mem_addr_q  <= {(state_q == WB_MEM) ? victim_q : tag_q, idx_q, w_q};
                  mem_wdata_q <= (state_q == WB_MEM) ? buf_q : '0;
               end else if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  mem_wr_q  <= 1'b0;
                  if (state_q == RF_MEM) begin
                     buf_q   <= mem_rdata;
                     state_q <= RF_WR;
                  end else if (w_q == LAST_W) begin
                     w_q     <= '0;
                     state_q <= RF_MEM;
                  end else begin
                     w_q     <= w_q + W_ONE;
                     state_q <= WB_RD;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cpu_rdata    = rdata_q;
   assign cpu_ack      = cpu_ack_q;
   assign busy         = (state_q != IDLE);
   assign set_idx      = set_idx_q;
   assign set_en       = set_en_q;
   assign set_cmp      = set_cmp_q;
   assign set_write    = set_write_q;
   assign set_rst      = set_rst_q;
   assign set_valid_in = set_valid_in_q;
   assign set_word     = set_word_q;
   assign set_tag      = set_tag_q;
   assign set_data_in  = set_data_q;
   assign mem_req      = mem_req_q;
   assign mem_wr       = mem_wr_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign hit_cnt      = hit_q;
   assign miss_cnt     = miss_q;

endmodule
